mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_if.sv | 34 +++
 rtl/mc_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath:
// instruction fields and ALU zero flag in, control strobes and debug state out.
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ZeroFlag;
  logic       initPC;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       PCLoad;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUop;
  logic [1:0] PCSrc;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, ZeroFlag,
    output initPC, IorD, MemRead, MemWrite, IRWrite, RegWrite, PCLoad,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCSrc, illegal, state
  );

  modport slave (
    output opcode, funct, ZeroFlag,
    input  initPC, IorD, MemRead, MemWrite, IRWrite, RegWrite, PCLoad,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCSrc, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// Moore FSM controller for a multicycle MIPS subset. Outputs are registered from
// the next state; only PCLoad mixes in ZeroFlag combinationally.
module mc_controller (
  input  logic          clk,
  input  logic          rst,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_IF      = 4'd1,
    S_ID      = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REXE    = 4'd7,
    S_RWB     = 4'd8,
    S_BEQ     = 4'd9,
    S_IEXE    = 4'd10,
    S_IWB     = 4'd11,
    S_JMP     = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14,
    S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic       is_lw_q, is_lw_d;
  logic [2:0] alu_lat_q, alu_lat_d;

  logic       init_pc_q, init_pc_d;
  logic       iord_q, iord_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       ir_write_q, ir_write_d;
  logic       reg_write_q, reg_write_d;
  logic       pc_write_q, pc_write_d;
  logic       pc_write_cond_q, pc_write_cond_d;
  logic [1:0] reg_dst_q, reg_dst_d;
  logic [1:0] memto_reg_q, memto_reg_d;
  logic       alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic       illegal_q, illegal_d;

  logic       funct_known;
  logic [2:0] funct_alu;

  always_comb begin
    funct_known = 1'b1;
    funct_alu   = ALU_ADD;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_known = 1'b0;
    endcase
  end

  // Instruction fields are only looked at in ID; everything needed later is latched here.
  always_comb begin
    state_d   = state_q;
    is_lw_d   = is_lw_q;
    alu_lat_d = alu_lat_q;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID: begin
        is_lw_d = (bus.opcode == OP_LW);
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_known) begin
              state_d   = S_REXE;
              alu_lat_d = funct_alu;
            end else if (bus.funct == FN_JR) begin
              state_d = S_JR;
            end else begin
              state_d = S_ILLEGAL;
            end
          end
          OP_BEQ:  state_d = S_BEQ;
          OP_ADDI: begin
            state_d   = S_IEXE;
            alu_lat_d = ALU_ADD;
          end
          OP_SLTI: begin
            state_d   = S_IEXE;
            alu_lat_d = ALU_SLT;
          end
          OP_J:    state_d = S_JMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_REXE:    state_d = S_RWB;
      S_IEXE:    state_d = S_IWB;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IF;
    endcase
  end

  // Output decode keyed on the next state so every control lands in its flop alongside state_q.
  always_comb begin
    init_pc_d       = 1'b0;
    iord_d          = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    ir_write_d      = 1'b0;
    reg_write_d     = 1'b0;
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    reg_dst_d       = 2'b00;
    memto_reg_d     = 2'b00;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    alu_op_d        = 3'b000;
    pc_src_d        = 2'b00;
    illegal_d       = 1'b0;
    case (state_d)
      S_INIT: init_pc_d = 1'b1;
      S_IF: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        pc_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
        alu_op_d    = ALU_ADD;
      end
      S_ID: begin
        alu_src_b_d = 2'b11;
        alu_op_d    = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        alu_op_d    = ALU_ADD;
      end
      S_MEMRD: begin
        iord_d     = 1'b1;
        mem_read_d = 1'b1;
      end
      S_MEMWB: begin
        memto_reg_d = 2'b01;
        reg_write_d = 1'b1;
      end
      S_MEMWR: begin
        iord_d      = 1'b1;
        mem_write_d = 1'b1;
      end
      S_REXE: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = alu_lat_d;
      end
      S_RWB: begin
        reg_dst_d   = 2'b01;
        reg_write_d = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = ALU_SUB;
        pc_write_cond_d = 1'b1;
        pc_src_d        = 2'b01;
      end
      S_IEXE: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        alu_op_d    = alu_lat_d;
      end
      S_IWB: reg_write_d = 1'b1;
      S_JMP: begin
        pc_write_d = 1'b1;
        pc_src_d   = 2'b10;
      end
      S_JAL: begin
        pc_write_d  = 1'b1;
        pc_src_d    = 2'b10;
        reg_write_d = 1'b1;
        reg_dst_d   = 2'b10;
        memto_reg_d = 2'b10;
      end
      S_JR: begin
        pc_write_d = 1'b1;
        pc_src_d   = 2'b11;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_INIT;
      is_lw_q         <= 1'b0;
      alu_lat_q       <= ALU_ADD;
      init_pc_q       <= 1'b1;
      iord_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      ir_write_q      <= 1'b0;
      reg_write_q     <= 1'b0;
      pc_write_q      <= 1'b0;
      pc_write_cond_q <= 1'b0;
      reg_dst_q       <= 2'b00;
      memto_reg_q     <= 2'b00;
      alu_src_a_q     <= 1'b0;
      alu_src_b_q     <= 2'b00;
      alu_op_q        <= 3'b000;
      pc_src_q        <= 2'b00;
      illegal_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_lw_q         <= is_lw_d;
      alu_lat_q       <= alu_lat_d;
      init_pc_q       <= init_pc_d;
      iord_q          <= iord_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      ir_write_q      <= ir_write_d;
      reg_write_q     <= reg_write_d;
      pc_write_q      <= pc_write_d;
      pc_write_cond_q <= pc_write_cond_d;
      reg_dst_q       <= reg_dst_d;
      memto_reg_q     <= memto_reg_d;
      alu_src_a_q     <= alu_src_a_d;
      alu_src_b_q     <= alu_src_b_d;
      alu_op_q        <= alu_op_d;
      pc_src_q        <= pc_src_d;
      illegal_q       <= illegal_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.initPC   = init_pc_q;
  assign bus.IorD     = iord_q;
  assign bus.MemRead  = mem_read_q;
  assign bus.MemWrite = mem_write_q;
  assign bus.IRWrite  = ir_write_q;
  assign bus.RegWrite = reg_write_q;
  assign bus.PCLoad   = pc_write_q | (pc_write_cond_q & bus.ZeroFlag);
  assign bus.RegDst   = reg_dst_q;
  assign bus.MemtoReg = memto_reg_q;
  assign bus.ALUSrcA  = alu_src_a_q;
  assign bus.ALUSrcB  = alu_src_b_q;
  assign bus.ALUop    = alu_op_q;
  assign bus.PCSrc    = pc_src_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction state traces and control
// vectors against a path/decode model, random instruction mix, and reset behaviour.
module tb_mc_controller;

  logic clk;
  logic rst;
  mc_controller_if bus ();

  mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int total = 0;
  int bad   = 0;

  int         exp_st[$];
  logic [3:0] obs_state [0:7];
  logic [19:0] obs_vec  [0:7];
  logic       zero_rec  [0:7];

  localparam logic [19:0] V_INIT    = 20'h80000;
  localparam logic [19:0] V_ILLEGAL = 20'h00001;

  // Control vector: {initPC,IorD,MemRead,MemWrite,IRWrite,RegWrite,PCLoad,
  //                  RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUop,PCSrc,illegal}
  function automatic logic [19:0] pack_obs();
    return {bus.initPC, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.RegWrite, bus.PCLoad, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUop, bus.PCSrc, bus.illegal};
  endfunction

  function automatic bit is_alu_fn(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  endfunction

  // Expected state walk for one instruction starting in IF; last entry is where it lands.
  task automatic model_path(input logic [5:0] op, input logic [5:0] fn);
    exp_st = {};
    exp_st.push_back(1);
    exp_st.push_back(2);
    if (op == 6'h23)      begin exp_st.push_back(3); exp_st.push_back(4); exp_st.push_back(5); exp_st.push_back(1); end
    else if (op == 6'h2B) begin exp_st.push_back(3); exp_st.push_back(6); exp_st.push_back(1); end
    else if (op == 6'h00 && is_alu_fn(fn)) begin exp_st.push_back(7); exp_st.push_back(8); exp_st.push_back(1); end
    else if (op == 6'h00 && fn == 6'h08)   begin exp_st.push_back(14); exp_st.push_back(1); end
    else if (op == 6'h04) begin exp_st.push_back(9); exp_st.push_back(1); end
    else if (op == 6'h08 || op == 6'h0A) begin exp_st.push_back(10); exp_st.push_back(11); exp_st.push_back(1); end
    else if (op == 6'h02) begin exp_st.push_back(12); exp_st.push_back(1); end
    else if (op == 6'h03) begin exp_st.push_back(13); exp_st.push_back(1); end
    else exp_st.push_back(15);
  endtask

  function automatic logic [19:0] exp_vec(input int s, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z);
    logic init_pc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, pcw = 0, pcwc = 0;
    logic ill = 0, srca = 0;
    logic [1:0] rdst = 0, m2r = 0, srcb = 0, psrc = 0;
    logic [2:0] aop = 0;
    case (s)
      0:  init_pc = 1;
      1:  begin mrd = 1; irw = 1; pcw = 1; srcb = 2'b01; aop = 3'b010; end
      2:  begin srcb = 2'b11; aop = 3'b010; end
      3:  begin srca = 1; srcb = 2'b10; aop = 3'b010; end
      4:  begin iord = 1; mrd = 1; end
      5:  begin m2r = 2'b01; rw = 1; end
      6:  begin iord = 1; mwr = 1; end
      7:  begin
            srca = 1;
            case (fn)
              6'h20: aop = 3'b010;
              6'h22: aop = 3'b110;
              6'h24: aop = 3'b000;
              6'h25: aop = 3'b001;
              default: aop = 3'b111;
            endcase
          end
      8:  begin rdst = 2'b01; rw = 1; end
      9:  begin srca = 1; aop = 3'b110; pcwc = 1; psrc = 2'b01; end
      10: begin srca = 1; srcb = 2'b10; aop = (op == 6'h0A) ? 3'b111 : 3'b010; end
      11: rw = 1;
      12: begin pcw = 1; psrc = 2'b10; end
      13: begin pcw = 1; psrc = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
      14: begin pcw = 1; psrc = 2'b11; end
      default: ill = 1;
    endcase
    return {init_pc, iord, mrd, mwr, irw, rw, pcw | (pcwc & z), rdst, m2r, srca, srcb, aop, psrc, ill};
  endfunction

  // Drives one instruction (real fields only during ID, noise elsewhere) and records outputs.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero);
    int n;
    n = exp_st.size() - 1;
    for (int k = 0; k < n; k++) begin
      bus.opcode   = (k == 1) ? op : 6'($urandom);
      bus.funct    = (k == 1) ? fn : 6'($urandom);
      bus.ZeroFlag = (k == 2) ? zero : 1'($urandom);
      zero_rec[k]  = bus.ZeroFlag;
      #1;
      obs_state[k] = bus.state;
      obs_vec[k]   = pack_obs();
      @(negedge clk);
    end
    obs_state[n] = bus.state;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.opcode = 6'h23; bus.funct = 6'h00; bus.ZeroFlag = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    total++;
    if (pack_obs() !== V_INIT) begin bad++; $display("FAIL reset_outputs got=%h want=%h", pack_obs(), V_INIT); end
    rst = 1'b1;
    #1;
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL release_no_edge got=%0d want=0", bus.state); end
    @(negedge clk);
    total++;
    if (bus.state !== 4'd1) begin bad++; $display("FAIL first_edge_if got=%0d want=1", bus.state); end
    $display("reset: state=%0d", bus.state);
  endtask

  task automatic test_lw();
    logic [19:0] ev;
    model_path(6'h23, 6'h3F);
    exec_instr(6'h23, 6'h3F, 1'b1);
    for (int k = 0; k < exp_st.size(); k++) begin
      total++;
      if (obs_state[k] !== 4'(exp_st[k])) begin bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", k, obs_state[k], exp_st[k]); end
      if (k < exp_st.size() - 1) begin
        ev = exp_vec(exp_st[k], 6'h23, 6'h3F, zero_rec[k]);
        total++;
        if (obs_vec[k] !== ev) begin bad++; $display("FAIL lw_ctrl[%0d] got=%h want=%h", k, obs_vec[k], ev); end
      end
    end
    $display("lw: cycles=%0d end_state=%0d", exp_st.size() - 1, obs_state[exp_st.size() - 1]);
  endtask

  task automatic test_rtype();
    logic [19:0] ev;
    logic [5:0] fns [0:5];
    fns = '{6'h22, 6'h20, 6'h24, 6'h25, 6'h2A, 6'h08};
    for (int i = 0; i < 6; i++) begin
      model_path(6'h00, fns[i]);
      exec_instr(6'h00, fns[i], 1'b0);
      for (int k = 0; k < exp_st.size(); k++) begin
        total++;
        if (obs_state[k] !== 4'(exp_st[k])) begin bad++; $display("FAIL rtype_state fn=%h [%0d] got=%0d want=%0d", fns[i], k, obs_state[k], exp_st[k]); end
        if (k < exp_st.size() - 1) begin
          ev = exp_vec(exp_st[k], 6'h00, fns[i], zero_rec[k]);
          total++;
          if (obs_vec[k] !== ev) begin bad++; $display("FAIL rtype_ctrl fn=%h [%0d] got=%h want=%h", fns[i], k, obs_vec[k], ev); end
        end
      end
      $display("rtype: funct=%h cycles=%0d", fns[i], exp_st.size() - 1);
    end
  endtask

  task automatic test_beq();
    logic [19:0] ev;
    for (int z = 1; z >= 0; z--) begin
      model_path(6'h04, 6'h00);
      exec_instr(6'h04, 6'h00, 1'(z));
      for (int k = 0; k < exp_st.size(); k++) begin
        total++;
        if (obs_state[k] !== 4'(exp_st[k])) begin bad++; $display("FAIL beq_state z=%0d [%0d] got=%0d want=%0d", z, k, obs_state[k], exp_st[k]); end
        if (k < exp_st.size() - 1) begin
          ev = exp_vec(exp_st[k], 6'h04, 6'h00, zero_rec[k]);
          total++;
          if (obs_vec[k] !== ev) begin bad++; $display("FAIL beq_ctrl z=%0d [%0d] got=%h want=%h", z, k, obs_vec[k], ev); end
        end
      end
      $display("beq: zero=%0d pcload_in_beq=%0d", z, obs_vec[2][13]);
    end
  endtask

  task automatic test_jumps();
    logic [19:0] ev;
    logic [5:0] ops [0:4];
    ops = '{6'h03, 6'h02, 6'h08, 6'h0A, 6'h2B};
    for (int i = 0; i < 5; i++) begin
      model_path(ops[i], 6'h15);
      exec_instr(ops[i], 6'h15, 1'b1);
      for (int k = 0; k < exp_st.size(); k++) begin
        total++;
        if (obs_state[k] !== 4'(exp_st[k])) begin bad++; $display("FAIL op_state op=%h [%0d] got=%0d want=%0d", ops[i], k, obs_state[k], exp_st[k]); end
        if (k < exp_st.size() - 1) begin
          ev = exp_vec(exp_st[k], ops[i], 6'h15, zero_rec[k]);
          total++;
          if (obs_vec[k] !== ev) begin bad++; $display("FAIL op_ctrl op=%h [%0d] got=%h want=%h", ops[i], k, obs_vec[k], ev); end
        end
      end
      $display("instr: opcode=%h cycles=%0d", ops[i], exp_st.size() - 1);
    end
  endtask

  task automatic test_illegal();
    logic [19:0] ev;
    model_path(6'h3F, 6'h20);
    exec_instr(6'h3F, 6'h20, 1'b0);
    for (int k = 0; k < exp_st.size(); k++) begin
      total++;
      if (obs_state[k] !== 4'(exp_st[k])) begin bad++; $display("FAIL illegal_state[%0d] got=%0d want=%0d", k, obs_state[k], exp_st[k]); end
      if (k < exp_st.size() - 1) begin
        ev = exp_vec(exp_st[k], 6'h3F, 6'h20, zero_rec[k]);
        total++;
        if (obs_vec[k] !== ev) begin bad++; $display("FAIL illegal_ctrl[%0d] got=%h want=%h", k, obs_vec[k], ev); end
      end
    end
    for (int c = 0; c < 10; c++) begin
      bus.opcode = 6'($urandom); bus.funct = 6'($urandom); bus.ZeroFlag = 1'($urandom);
      #1;
      total++;
      if (bus.state !== 4'd15 || pack_obs() !== V_ILLEGAL) begin
        bad++; $display("FAIL illegal_hold[%0d] got state=%0d ctrl=%h want state=15 ctrl=%h", c, bus.state, pack_obs(), V_ILLEGAL);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || pack_obs() !== V_INIT) begin
      bad++; $display("FAIL illegal_reset got state=%0d ctrl=%h want state=0 ctrl=%h", bus.state, pack_obs(), V_INIT);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.state !== 4'd1) begin bad++; $display("FAIL illegal_recover got=%0d want=1", bus.state); end
    $display("illegal: held 10 cycles, recovered state=%0d", bus.state);
  endtask

  task automatic test_reset_midop();
    bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
    @(negedge clk);
    bus.opcode = 6'h2B;
    @(negedge clk);
    bus.opcode = 6'($urandom);
    @(negedge clk);
    #1;
    total++;
    if (bus.state !== 4'd6 || bus.MemWrite !== 1'b1) begin
      bad++; $display("FAIL midop_memwr got state=%0d MemWrite=%b want state=6 MemWrite=1", bus.state, bus.MemWrite);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.MemWrite !== 1'b0 || bus.initPC !== 1'b1 || bus.state !== 4'd0) begin
      bad++; $display("FAIL midop_reset got MemWrite=%b initPC=%b state=%0d want 0 1 0", bus.MemWrite, bus.initPC, bus.state);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.state !== 4'd1) begin bad++; $display("FAIL midop_recover got=%0d want=1", bus.state); end
    $display("midop_reset: MemWrite dropped, state=%0d", bus.state);
  endtask

  task automatic test_random();
    logic [19:0] ev;
    logic [5:0] op, fn;
    logic z;
    logic [5:0] alu_fns [0:4];
    int errs;
    alu_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < 40; i++) begin
      fn = 6'($urandom);
      z  = 1'($urandom);
      case ($urandom_range(0, 9))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin op = 6'h00; fn = alu_fns[$urandom_range(0, 4)]; end
        3: begin op = 6'h00; fn = 6'h08; end
        4: op = 6'h04;
        5: op = 6'h08;
        6: op = 6'h0A;
        7: op = 6'h02;
        8: op = 6'h03;
        default: op = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
      endcase
      model_path(op, fn);
      exec_instr(op, fn, z);
      errs = 0;
      for (int k = 0; k < exp_st.size(); k++) begin
        total++;
        if (obs_state[k] !== 4'(exp_st[k])) begin errs++; bad++; $display("FAIL rand_state op=%h fn=%h [%0d] got=%0d want=%0d", op, fn, k, obs_state[k], exp_st[k]); end
        if (k < exp_st.size() - 1) begin
          ev = exp_vec(exp_st[k], op, fn, zero_rec[k]);
          total++;
          if (obs_vec[k] !== ev) begin errs++; bad++; $display("FAIL rand_ctrl op=%h fn=%h [%0d] got=%h want=%h", op, fn, k, obs_vec[k], ev); end
        end
      end
      $display("random[%0d]: opcode=%h funct=%h zero=%0d end_state=%0d errs=%0d", i, op, fn, z, obs_state[exp_st.size() - 1], errs);
      if (exp_st[exp_st.size() - 1] == 15 || obs_state[exp_st.size() - 1] != 4'd1) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jumps();
    test_reset_midop();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
